mac_sequencer: RTL and testbench

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_pkg.sv | 16 +
 rtl/mul_unit.sv | 15 +
 rtl/mac_sequencer.sv | 116 +++++++++++
 tb/tb_mac_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and defaults for the multiply-accumulate sequencer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package mac_pkg;

  localparam int MAC_OPW_DEF  = 2;
  localparam int MAC_OUTW_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL1,
    ST_MUL2,
    ST_DONE
  } mac_state_t;

endpackage

// File: rtl/mul_unit.sv
// Combinational OPW x OPW unsigned multiplier with a full-width product.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller sequences operands.
module mul_unit #(
  parameter int OPW = 2
) (
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic [2*OPW-1:0] p
);

  // Zero-extend both operands so the product is computed at full width.
  assign p = {{OPW{1'b0}}, a} * {{OPW{1'b0}}, b};

endmodule

// File: rtl/mac_sequencer.sv
// Computes a*b + c*d through one shared multiplier over two cycles; optional
// running sum across transactions (macro MAC_SEQUENCER_ACCUM_EN) adds a saturating accumulator and clr.
// Latency: out_valid rises on the third edge counting the accepting edge; one result per 3 cycles.
// Backpressure: result held in DONE until out_ready; in_ready low while multiplying or stalled.
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int OPW  = MAC_OPW_DEF,
  // Must be at least 2*OPW+1 so a single transaction never overflows.
  parameter int OUTW = MAC_OUTW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
`ifdef MAC_SEQUENCER_ACCUM_EN
  input  logic            clr,
`endif
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [OPW-1:0]  a,
  input  logic [OPW-1:0]  b,
  input  logic [OPW-1:0]  c,
  input  logic [OPW-1:0]  d,
  output logic [OUTW-1:0] out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy
);

  mac_state_t        state;
  logic [OPW-1:0]    ra, rb, rc, rd;
  logic [OUTW-1:0]   acc;
  logic [OPW-1:0]    mul_a, mul_b;
  logic [2*OPW-1:0]  prod;
  logic [OUTW-1:0]   add_base;
  logic [OUTW:0]     sum;
  logic [OUTW-1:0]   next_acc;
  logic              accept;

  assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign busy     = (state != ST_IDLE);

  mul_unit #(.OPW(OPW)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (prod)
  );

  // Steer captured operands into the shared multiplier and pick the addend base.
  always_comb begin
    mul_a    = rc;
    mul_b    = rd;
    add_base = acc;
    if (state == ST_MUL1) begin
      mul_a = ra;
      mul_b = rb;
`ifdef MAC_SEQUENCER_ACCUM_EN
      add_base = acc;
`else
      add_base = '0;
`endif
    end
  end

  // One spare bit detects overflow; clamp to all-ones when it is set.
  assign sum      = {1'b0, add_base} + {{(OUTW+1-2*OPW){1'b0}}, prod};
  assign next_acc = sum[OUTW] ? {OUTW{1'b1}} : sum[OUTW-1:0];

  // Sequencer: capture operands, two multiply phases, then hold the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      acc       <= '0;
      ra        <= '0;
      rb        <= '0;
      rc        <= '0;
      rd        <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        ra <= a;
        rb <= b;
        rc <= c;
        rd <= d;
      end
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_MUL1;
        end
        ST_MUL1: begin
          acc   <= next_acc;
          state <= ST_MUL2;
        end
        ST_MUL2: begin
          acc       <= next_acc;
          out       <= next_acc;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= accept ? ST_MUL1 : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
`ifdef MAC_SEQUENCER_ACCUM_EN
      // Clear wins over a simultaneous accept; the new set then sums from zero.
      if (clr && ((state == ST_IDLE) || (state == ST_DONE))) acc <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Self-checking bench for mac_sequencer: directed table, stall/reset sequences, random traffic.
// Edge counting: the accepting edge is edge 1, out_valid is seen after edge 3.
// Works with and without MAC_SEQUENCER_ACCUM_EN.
module tb_mac_sequencer;

  localparam int OPW    = 2;
  localparam int OUTW   = 5;
  localparam int OUTMAX = (1 << OUTW) - 1;
  localparam int NV     = 8;

  logic            clk;
  logic            rst_n;
  logic            clr;
  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  a, b, c, d;
  logic [OUTW-1:0] out;
  logic            out_valid;
  logic            out_ready;
  logic            busy;

  int n_cmp;
  int n_err;
  int model_acc;

  typedef struct {
    int a;
    int b;
    int c;
    int d;
    int sum;
  } vec_t;

  vec_t tbl [NV];

  mac_sequencer #(.OPW(OPW), .OUTW(OUTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef MAC_SEQUENCER_ACCUM_EN
    .clr       (clr),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int va, input int vb, input int vc, input int vd);
    a = OPW'(va);
    b = OPW'(vb);
    c = OPW'(vc);
    d = OPW'(vd);
  endtask

  task automatic drive_rand();
    drive($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  // Result the next transaction with plain sum s should produce.
  function automatic int expect_next(input int s);
`ifdef MAC_SEQUENCER_ACCUM_EN
    model_acc = model_acc + s;
    if (model_acc > OUTMAX) model_acc = OUTMAX;
`else
    model_acc = s;
`endif
    return model_acc;
  endfunction

  initial begin
    int  exp;
    bit  inflight, have_res, acc_now, exp_rdy;
    int  remain, pend, res;

    n_cmp = 0; n_err = 0; model_acc = 0;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(0, 0, 0, 0);

    tbl[0] = '{1, 2, 1, 2, 4};
    tbl[1] = '{2, 2, 2, 2, 8};
    tbl[2] = '{3, 1, 1, 2, 5};
    tbl[3] = '{3, 2, 3, 2, 12};
    tbl[4] = '{3, 3, 3, 3, 18};
    tbl[5] = '{0, 0, 0, 0, 0};
    tbl[6] = '{3, 3, 0, 0, 9};
    tbl[7] = '{0, 1, 3, 3, 9};

    // ---- reset state ----
    @(negedge clk);
    check("rst_out", 32'(out), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 1);
    @(negedge clk);

    // ---- table: back-to-back with operand toggling during MUL1/MUL2 ----
    in_valid = 1'b1; out_ready = 1'b1;
    drive(tbl[0].a, tbl[0].b, tbl[0].c, tbl[0].d);
    for (int i = 0; i < NV; i++) begin
      #1;
      check("tbl_ready_at_accept", 32'(in_ready), 1);
      exp = expect_next(tbl[i].sum);
      @(negedge clk);
      check("tbl_ready_mul1", 32'(in_ready), 0);
      check("tbl_busy_mul1", 32'(busy), 1);
      drive_rand();
      @(negedge clk);
      check("tbl_ready_mul2", 32'(in_ready), 0);
      check("tbl_valid_mul2", 32'(out_valid), 0);
      drive_rand();
      @(negedge clk);
      check("tbl_out_valid", 32'(out_valid), 1);
      check("tbl_out", 32'(out), 32'(exp));
      if (i + 1 < NV) drive(tbl[i+1].a, tbl[i+1].b, tbl[i+1].c, tbl[i+1].d);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    check("tbl_idle_valid", 32'(out_valid), 0);
    check("tbl_idle_busy", 32'(busy), 0);
    check("tbl_idle_out_held", 32'(out), 32'(exp));

    // ---- stall in DONE: result held for 5 cycles ----
    drive(3, 3, 3, 3); in_valid = 1'b1; out_ready = 1'b0;
    exp = expect_next(18);
    @(negedge clk); drive_rand();
    @(negedge clk); drive_rand();
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(out_valid), 1);
      check("stall_out", 32'(out), 32'(exp));
      drive_rand(); in_valid = 1'b1;
      #1;
      check("stall_ready", 32'(in_ready), 0);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check("stall_release_ready", 32'(in_ready), 1);
    @(negedge clk);
    check("stall_done_valid", 32'(out_valid), 0);
    check("stall_done_busy", 32'(busy), 0);
    check("stall_done_out_held", 32'(out), 32'(exp));

    // ---- reset during MUL2 ----
    drive(3, 2, 3, 2); in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out", 32'(out), 0);
    check("midrst_valid", 32'(out_valid), 0);
    check("midrst_busy", 32'(busy), 0);
    model_acc = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("midrst_no_result", 32'(out_valid), 0);
      check("midrst_idle", 32'(busy), 0);
    end

    // ---- random traffic against a latency/queue model ----
    inflight = 0; have_res = 0; remain = 0; pend = 0; res = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      check("rnd_valid", 32'(out_valid), 32'(have_res));
      check("rnd_busy", 32'(busy), 32'(inflight || have_res));
      if (have_res) check("rnd_out", 32'(out), 32'(res));
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      drive_rand();
      #1;
      exp_rdy = !inflight && (!have_res || out_ready);
      check("rnd_ready", 32'(in_ready), 32'(exp_rdy));
      acc_now = in_valid && exp_rdy;
      @(posedge clk);
      if (have_res && out_ready) have_res = 0;
      if (inflight) begin
        remain--;
        if (remain == 0) begin
          inflight = 0;
          have_res = 1;
          res = pend;
        end
      end
      if (acc_now) begin
        inflight = 1;
        remain = 2;
        pend = expect_next(int'(a) * int'(b) + int'(c) * int'(d));
      end
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rnd_drained", 32'(out_valid), 0);

`ifdef MAC_SEQUENCER_ACCUM_EN
    // ---- clear then a fresh transaction starts from zero ----
    clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    model_acc = 0;
    drive(1, 2, 1, 2); in_valid = 1'b1;
    exp = expect_next(4);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("clr_out_valid", 32'(out_valid), 1);
    check("clr_out", 32'(out), 32'(exp));
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
